fifo_rd_arb: RTL and testbench
==============================

// Module: fifo_rd_arb
// PURPOSE
//  Read-side scheduler for the async FIFO read port (rclk domain). Shares the single
//  pop interface (rinc/rempty/rdata) among NREQ consumers using round-robin, burst-granular
//  arbitration. Issues pops to the FIFO read-address generator and tags the popped data
//  with the owner's ID. Aborts a stalled burst after TIMEOUT empty cycles.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  IDW      2   width of dout_id; 2**IDW >= NREQ
//  DSIZE    8   FIFO data width
//  BLEN_W   4   burst-length field width; max burst 2**BLEN_W-1 words
//  TIMEOUT  16  consecutive empty/no-pop cycles in BURST before early termination (>=2)
// PORTS
//  rclk        in   1             read-domain clock
//  rrst        in   1             synchronous reset, active-high
//  req         in   NREQ          per-requester burst request, level, held until done
//  req_len     in   NREQ*BLEN_W   burst length, requester i at [i*BLEN_W +: BLEN_W]
//  gnt         out  NREQ          one-hot grant, high for whole burst
//  rempty      in   1             FIFO empty flag
//  rinc        out  1             FIFO pop strobe
//  rdata       in   DSIZE         FIFO word at current read address (comb. read)
//  dout_rdy    in   1             downstream accepts dout this cycle
//  dout        out  DSIZE         = rdata
//  dout_vld    out  1             = rinc
//  dout_id     out  IDW           binary index of granted requester
//  done        out  1             1-cycle pulse, burst finished
//  done_short  out  1             with done: burst ended by timeout, words missing
//  busy        out  1             state != IDLE
// BEHAVIOUR
//  - Reset (rrst=1 at rclk edge): state=IDLE, gnt=0, cnt=0, stall=0, done=0, done_short=0,
//    rr_ptr=NREQ-1 (req0 highest priority first). rinc/dout_vld low from the first cycle
//    after reset, including reset mid-burst; no pop issued while rrst is sampled high.
//  - States: IDLE -> BURST -> DONE -> IDLE.
//  - IDLE: if |req, pick first set index scanning rr_ptr+1, rr_ptr+2, ... mod NREQ.
//    Next cycle: gnt[i]=1, dout_id=i, cnt=req_len[i], rr_ptr=i, stall=0, state=BURST.
//    req_len=0: go straight to DONE (gnt pulses one cycle, no pop, done_short=0).
//  - BURST: rinc = !rempty & dout_rdy (comb. from registered state). Per pop cnt-=1,
//    stall=0. Cycle with no pop: stall+=1. Pop when cnt==1 -> DONE. stall reaching
//    TIMEOUT-1 on a no-pop cycle -> DONE with done_short=1. req deassert in BURST ignored.
//  - DONE: gnt=0, rinc=0, done=1 (+done_short if set) for exactly 1 cycle, then IDLE.
//    Requester must drop req in the done cycle; req still high in next IDLE is a new request.
//  - Latency: req sampled cycle T -> gnt/first pop possible T+1. Last pop at T ->
//    done at T+1 -> next grant at T+3 earliest. Max rate: len words per len+2 cycles.
//  - Never pops when rempty=1 (no underflow); dout_rdy=0 stalls pop, counts toward TIMEOUT.
//  - cnt/stall are BLEN_W / clog2(TIMEOUT) bit unsigned; no wrap (bounded by transitions).
//  - rr_ptr updates only on grant; a requester cannot win twice if another is pending.
// TESTING
//  1 Reset: rrst=1 for 3 cycles with req=4'hF -> gnt=0, rinc=0, done=0, busy=0 throughout.
//  2 Single burst: req=4'b0001, len0=3, FIFO holds 5 words, dout_rdy=1 -> gnt=0001 at T+1,
//    3 pops T+1..T+3 with dout_id=0, done at T+4, 2 words remain, no 4th pop.
//  3 Round-robin: req=4'hF, all len=2 -> grant order 0,1,2,3,0; each exactly 2 pops.
//  4 Empty stall: len=4, FIFO holds 1 word, TIMEOUT=16 -> 1 pop, then done=1,
//    done_short=1 after 16 no-pop cycles; rinc never high with rempty=1.
//  5 Backpressure: dout_rdy toggles 1,0,1,0 mid-burst len=4 -> pops only when dout_rdy=1,
//    done after 4th pop, done_short=0.
//  6 Reset mid-burst: assert rrst after 2 of 5 pops -> next cycle gnt=0, rinc=0, state IDLE;
//    after release, req0 re-granted with full fresh len.

Source files
------------

// File: rtl/fifo_rd_arb.sv
// Read-side scheduler for the async FIFO: round-robin, burst-granular sharing of the
// single pop port among NREQ consumers, with owner tagging and stall timeout.
module fifo_rd_arb #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int DSIZE   = 8,
  parameter int BLEN_W  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     rclk,
  input  logic                     rrst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*BLEN_W-1:0]   req_len,
  output logic [NREQ-1:0]          gnt,
  input  logic                     rempty,
  output logic                     rinc,
  input  logic [DSIZE-1:0]         rdata,
  input  logic                     dout_rdy,
  output logic [DSIZE-1:0]         dout,
  output logic                     dout_vld,
  output logic [IDW-1:0]           dout_id,
  output logic                     done,
  output logic                     done_short,
  output logic                     busy
);

  localparam int SW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]        state;
  logic [BLEN_W-1:0] cnt;
  logic [SW-1:0]     stall;
  logic [IDW-1:0]    rr_ptr;

  logic              pick_found;
  logic [IDW-1:0]    pick_idx;
  logic [BLEN_W-1:0] pick_len;
  logic [NREQ-1:0]   pick_onehot;

  // Scan starts just after the last winner so a pending requester is never skipped twice.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      logic [IDW-1:0] cand;
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign pick_len    = req_len[pick_idx*BLEN_W +: BLEN_W];
  assign pick_onehot = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;

  // Gated by rrst so that no word is lost from the FIFO during a reset cycle.
  assign rinc     = (state == ST_BURST) && !rrst && !rempty && dout_rdy;
  assign dout_vld = rinc;
  assign dout     = rdata;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      dout_id    <= '0;
      cnt        <= '0;
      stall      <= '0;
      rr_ptr     <= IDW'(NREQ - 1);
      done       <= 1'b0;
      done_short <= 1'b0;
    end else begin
      done       <= 1'b0;
      done_short <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            gnt     <= pick_onehot;
            dout_id <= pick_idx;
            rr_ptr  <= pick_idx;
            cnt     <= pick_len;
            stall   <= '0;
            // A zero-length request still completes a handshake so the requester sees done.
            if (pick_len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_BURST;
            end
          end
        end
        ST_BURST: begin
          if (rinc) begin
            cnt   <= cnt - BLEN_W'(1);
            stall <= '0;
            if (cnt == BLEN_W'(1)) begin
              state <= ST_DONE;
              gnt   <= '0;
              done  <= 1'b1;
            end
          end else if (stall == SW'(TIMEOUT - 1)) begin
            state      <= ST_DONE;
            gnt        <= '0;
            done       <= 1'b1;
            done_short <= 1'b1;
          end else begin
            stall <= stall + SW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          gnt   <= '0;
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_arb.sv
// Bench for fifo_rd_arb: directed scenarios plus random traffic, checked every cycle
// against a burst-level reference model and a queue standing in for the FIFO.
module tb_fifo_rd_arb;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int DSIZE   = 8;
  localparam int BLEN_W  = 4;
  localparam int TIMEOUT = 16;

  logic                   rclk = 1'b0;
  logic                   rrst;
  logic [NREQ-1:0]        req;
  logic [NREQ*BLEN_W-1:0] req_len;
  logic [NREQ-1:0]        gnt;
  logic                   rempty;
  logic                   rinc;
  logic [DSIZE-1:0]       rdata;
  logic                   dout_rdy;
  logic [DSIZE-1:0]       dout;
  logic                   dout_vld;
  logic [IDW-1:0]         dout_id;
  logic                   done;
  logic                   done_short;
  logic                   busy;

  fifo_rd_arb #(
    .NREQ(NREQ), .IDW(IDW), .DSIZE(DSIZE), .BLEN_W(BLEN_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .rclk(rclk), .rrst(rrst), .req(req), .req_len(req_len), .gnt(gnt),
    .rempty(rempty), .rinc(rinc), .rdata(rdata), .dout_rdy(dout_rdy),
    .dout(dout), .dout_vld(dout_vld), .dout_id(dout_id), .done(done),
    .done_short(done_short), .busy(busy)
  );

  always #5 rclk = ~rclk;

  int n_cmp = 0;
  int n_bad = 0;

  // Burst-level reference: 0 waiting, 1 serving a burst, 2 reporting completion.
  int m_phase = 0;
  int m_owner = 0;
  int m_last  = NREQ - 1;
  int m_len   = 0;
  int m_popped = 0;
  int m_quiet = 0;
  bit m_short = 1'b0;
  bit m_zero  = 1'b0;

  logic [DSIZE-1:0] fifo_q[$];

  int gnt_log[$];
  int pops_log[$];
  int dur_log[$];
  bit short_log[$];
  int cur_pops  = 0;
  int grant_cyc = 0;
  int cyc       = 0;
  logic [NREQ-1:0] prev_gnt = '0;

  int auto_mode  = 0;
  bit toggle_rdy = 1'b0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic refresh_fifo();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? '0 : fifo_q[0];
  endtask

  task automatic model_step(input bit pop);
    int w;
    if (rrst) begin
      m_phase = 0;
      m_last  = NREQ - 1;
      m_zero  = 1'b0;
      m_short = 1'b0;
    end else begin
      case (m_phase)
        0: if (req != '0) begin
          w = -1;
          for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_last + k) % NREQ;
            if (w < 0 && req[c]) w = c;
          end
          m_owner  = w;
          m_last   = w;
          m_len    = int'(req_len[w*BLEN_W +: BLEN_W]);
          m_popped = 0;
          m_quiet  = 0;
          m_short  = 1'b0;
          m_zero   = (m_len == 0);
          m_phase  = m_zero ? 2 : 1;
        end
        1: begin
          if (pop) begin
            m_popped++;
            m_quiet = 0;
            if (m_popped == m_len) m_phase = 2;
          end else begin
            m_quiet++;
            if (m_quiet == TIMEOUT) begin
              m_phase = 2;
              m_short = 1'b1;
            end
          end
        end
        default: begin
          m_phase = 0;
          m_zero  = 1'b0;
          m_short = 1'b0;
        end
      endcase
    end
  endtask

  // One clock: compare at the falling edge, then advance FIFO and model at the rising edge.
  task automatic cycle();
    logic [NREQ-1:0] exp_gnt;
    bit exp_rinc;
    bit popped;
    @(negedge rclk);
    cyc++;
    exp_rinc = (m_phase == 1) && !rrst && (fifo_q.size() != 0) && dout_rdy;
    exp_gnt  = ((m_phase == 1) || (m_phase == 2 && m_zero)) ? (NREQ'(1) << m_owner) : '0;
    check_output("gnt", 32'(gnt), 32'(exp_gnt));
    check_output("rinc", 32'(rinc), 32'(exp_rinc));
    check_output("dout_vld", 32'(dout_vld), 32'(exp_rinc));
    check_output("done", 32'(done), 32'(m_phase == 2));
    check_output("done_short", 32'(done_short), 32'(m_phase == 2 && m_short));
    check_output("busy", 32'(busy), 32'(m_phase != 0));
    check_output("underflow", 32'(rinc & rempty), 32'd0);
    if (exp_gnt != '0) check_output("dout_id", 32'(dout_id), 32'(m_owner));
    if (exp_rinc) check_output("dout", 32'(dout), 32'(fifo_q[0]));

    if (rrst) begin
      cur_pops = 0;
    end else begin
      if (gnt != '0 && prev_gnt == '0) begin
        gnt_log.push_back(onehot_idx(gnt));
        grant_cyc = cyc;
        cur_pops  = 0;
      end
      if (rinc) cur_pops++;
      if (done) begin
        pops_log.push_back(cur_pops);
        short_log.push_back(done_short);
        dur_log.push_back(cyc - grant_cyc);
        cur_pops = 0;
      end
    end
    prev_gnt = gnt;
    popped   = rinc;

    @(posedge rclk);
    if (popped && fifo_q.size() != 0) void'(fifo_q.pop_front());
    model_step(exp_rinc);
    #1;
    refresh_fifo();
  endtask

  // Requesters drop req in their done cycle; modes add re-arming or random traffic.
  task automatic apply_stimulus();
    logic [NREQ-1:0] dropped;
    dropped = '0;
    if (m_phase == 2) begin
      req[m_owner]     = 1'b0;
      dropped[m_owner] = 1'b1;
    end
    if (auto_mode == 1) begin
      req = req | ~dropped;
    end else if (auto_mode == 2) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && !dropped[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_len[i*BLEN_W +: BLEN_W] = ($urandom_range(0, 7) == 0) ?
            BLEN_W'($urandom_range(0, 15)) : BLEN_W'($urandom_range(0, 5));
        end
      end
      dout_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 12) fifo_q.push_back(DSIZE'($urandom));
      rrst = ($urandom_range(0, 199) == 0);
    end
    if (toggle_rdy) dout_rdy = !dout_rdy;
    refresh_fifo();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      apply_stimulus();
      cycle();
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((req != '0 || busy !== 1'b0) && k < budget) begin
      apply_stimulus();
      cycle();
      k++;
    end
    check_output("drain_timeout", 32'(req != '0 || busy !== 1'b0), 32'd0);
  endtask

  task automatic fill_fifo(input int n);
    repeat (n) fifo_q.push_back(DSIZE'($urandom));
    refresh_fifo();
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    pops_log.delete();
    dur_log.delete();
    short_log.delete();
  endtask

  initial begin
    int k;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    rrst     = 1'b1;
    req      = 4'hF;
    req_len  = {4{BLEN_W'(2)}};
    dout_rdy = 1'b1;
    refresh_fifo();
    @(posedge rclk);
    #1;

    $display("[TB] reset with all requests high");
    repeat (3) cycle();
    req  = '0;
    rrst = 1'b0;

    $display("[TB] single burst of 3 from a FIFO holding 5");
    clear_logs();
    fill_fifo(5);
    req_len[0 +: BLEN_W] = BLEN_W'(3);
    req = 4'b0001;
    drain(20);
    check_output("single_left", 32'(fifo_q.size()), 32'd2);
    if (pops_log.size() >= 1) begin
      check_output("single_pops", 32'(pops_log[0]), 32'd3);
      check_output("single_dur", 32'(dur_log[0]), 32'd3);
      check_output("single_owner", 32'(gnt_log[0]), 32'd0);
    end else check_output("single_done_seen", 32'(pops_log.size()), 32'd1);

    $display("[TB] round robin over four requesters");
    rrst = 1'b1;
    cycle();
    rrst = 1'b0;
    clear_logs();
    fifo_q.delete();
    fill_fifo(20);
    req_len   = {4{BLEN_W'(2)}};
    req       = 4'hF;
    auto_mode = 1;
    k = 0;
    while (gnt_log.size() < 5 && k < 60) begin
      run(1);
      k++;
    end
    auto_mode = 0;
    drain(80);
    check_output("rr_grants_seen", 32'(gnt_log.size() >= 5), 32'd1);
    if (gnt_log.size() >= 5 && pops_log.size() >= 4) begin
      for (int i = 0; i < 5; i++) check_output("rr_order", 32'(gnt_log[i]), 32'(exp_order[i]));
      for (int i = 0; i < 4; i++) check_output("rr_pops", 32'(pops_log[i]), 32'd2);
    end

    $display("[TB] empty-FIFO stall ending in timeout");
    clear_logs();
    fifo_q.delete();
    fill_fifo(1);
    req_len[2*BLEN_W +: BLEN_W] = BLEN_W'(4);
    req = 4'b0100;
    drain(60);
    if (pops_log.size() >= 1) begin
      check_output("stall_pops", 32'(pops_log[0]), 32'd1);
      check_output("stall_short", 32'(short_log[0]), 32'd1);
      check_output("stall_dur", 32'(dur_log[0]), 32'(TIMEOUT + 1));
    end else check_output("stall_done_seen", 32'(pops_log.size()), 32'd1);

    $display("[TB] downstream backpressure mid-burst");
    clear_logs();
    fill_fifo(10);
    req_len[1*BLEN_W +: BLEN_W] = BLEN_W'(4);
    req        = 4'b0010;
    dout_rdy   = 1'b1;
    toggle_rdy = 1'b1;
    drain(40);
    toggle_rdy = 1'b0;
    dout_rdy   = 1'b1;
    if (pops_log.size() >= 1) begin
      check_output("bp_pops", 32'(pops_log[0]), 32'd4);
      check_output("bp_short", 32'(short_log[0]), 32'd0);
      check_output("bp_dur", 32'(dur_log[0]), 32'd7);
    end else check_output("bp_done_seen", 32'(pops_log.size()), 32'd1);

    $display("[TB] reset in the middle of a burst");
    clear_logs();
    fifo_q.delete();
    fill_fifo(10);
    req_len[0 +: BLEN_W] = BLEN_W'(5);
    req = 4'b0001;
    k = 0;
    while (cur_pops < 2 && k < 30) begin
      run(1);
      k++;
    end
    check_output("mid_two_pops", 32'(cur_pops), 32'd2);
    rrst = 1'b1;
    run(1);
    rrst = 1'b0;
    drain(40);
    check_output("mid_left", 32'(fifo_q.size()), 32'd3);
    if (pops_log.size() >= 1) begin
      check_output("mid_regrant", 32'(gnt_log[gnt_log.size()-1]), 32'd0);
      check_output("mid_fresh_len", 32'(pops_log[pops_log.size()-1]), 32'd5);
    end else check_output("mid_done_seen", 32'(pops_log.size()), 32'd1);

    $display("[TB] random traffic");
    clear_logs();
    auto_mode = 2;
    run(800);
    auto_mode = 0;
    rrst      = 1'b0;
    dout_rdy  = 1'b1;
    drain(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
